carryskip_bist: RTL



---
 rtl/carryskip_bist.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/carryskip_bist.sv
// carryskip_bist: built-in self-test engine for the 8-bit carry-skip adder.
// An LFSR produces operand/carry-in vectors. Each vector is applied, allowed to
// settle, and the adder's {cout,sum} is checked against a behavioural sum.
// Optional build macro: BIST_FAIL_CAPTURE_EN adds capture of the first
// failing vector (fail_vld/fail_a/fail_b/fail_cin/fail_idx).
module carryskip_bist #(
   parameter int                 WIDTH         = 8,
   parameter int                 N_VECTORS     = 256,
   parameter int                 SETTLE_CYCLES = 2,
   parameter logic [2*WIDTH-1:0] SEED          = 16'hACE1,
   parameter int                 ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             op_cin,
   input  logic [WIDTH-1:0] dut_sum,
   input  logic             dut_cout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt
`ifdef BIST_FAIL_CAPTURE_EN
   ,
   output logic             fail_vld,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic             fail_cin,
   output logic [15:0]      fail_idx
`endif
);

   localparam int LW     = 2 * WIDTH;
   localparam int WAIT_W = ($clog2(SETTLE_CYCLES + 1) > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [LW-1:0]     LFSR_MASK = LW'(16'hB400);
   localparam logic [ERR_W-1:0]  ERR_MAX   = '1;
   localparam logic [15:0]       LAST_VEC  = 16'(N_VECTORS - 1);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(SETTLE_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_APPLY,
      S_CHECK,
      S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [LW-1:0]     lfsr, lfsr_nxt;
   logic [15:0]       vec_cnt, vec_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic [WIDTH-1:0]  op_a_nxt, op_b_nxt;
   logic              op_cin_nxt;
   logic              busy_nxt, done_nxt, pass_nxt;
   logic [ERR_W-1:0]  err_nxt;
   logic [WIDTH:0]    ref_sum;
   logic              mismatch;
   logic              start_run;

   // Galois right-shift step: feedback taps applied when the bit shifted out is 1.
   function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] l);
      return l[0] ? ((l >> 1) ^ LFSR_MASK) : (l >> 1);
   endfunction

   assign ref_sum   = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
   assign mismatch  = ({dut_cout, dut_sum} != ref_sum);
   assign start_run = ((state == S_IDLE) || (state == S_DONE)) && start;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and next register values; everything holds unless a state acts on it.
   always_comb begin
      state_nxt  = state;
      lfsr_nxt   = lfsr;
      vec_nxt    = vec_cnt;
      wait_nxt   = wait_cnt;
      op_a_nxt   = op_a;
      op_b_nxt   = op_b;
      op_cin_nxt = op_cin;
      busy_nxt   = busy;
      done_nxt   = done;
      pass_nxt   = pass;
      err_nxt    = err_cnt;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nxt = S_LOAD;
               lfsr_nxt  = SEED;
               vec_nxt   = '0;
               err_nxt   = '0;
               done_nxt  = 1'b0;
               pass_nxt  = 1'b0;
               busy_nxt  = 1'b1;
            end
         end
         S_LOAD: begin
            state_nxt  = S_APPLY;
            wait_nxt   = WAIT_INIT;
            op_a_nxt   = lfsr[WIDTH-1:0];
            op_b_nxt   = lfsr[LW-1:WIDTH];
            op_cin_nxt = lfsr[LW-1] ^ lfsr[0];
         end
         S_APPLY: begin
            if (wait_cnt != '0) wait_nxt = wait_cnt - WAIT_W'(1);
            else                state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (mismatch && (err_cnt != ERR_MAX)) err_nxt = err_cnt + ERR_W'(1);
            lfsr_nxt = lfsr_step(lfsr);
            if (vec_cnt == LAST_VEC) begin
               state_nxt = S_DONE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               pass_nxt  = (err_nxt == '0);
            end else begin
               state_nxt  = S_APPLY;
               vec_nxt    = vec_cnt + 16'd1;
               wait_nxt   = WAIT_INIT;
               op_a_nxt   = lfsr_nxt[WIDTH-1:0];
               op_b_nxt   = lfsr_nxt[LW-1:WIDTH];
               op_cin_nxt = lfsr_nxt[LW-1] ^ lfsr_nxt[0];
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr     <= SEED;
         vec_cnt  <= '0;
         wait_cnt <= '0;
         op_a     <= '0;
         op_b     <= '0;
         op_cin   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= '0;
      end else begin
         lfsr     <= lfsr_nxt;
         vec_cnt  <= vec_nxt;
         wait_cnt <= wait_nxt;
         op_a     <= op_a_nxt;
         op_b     <= op_b_nxt;
         op_cin   <= op_cin_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         pass     <= pass_nxt;
         err_cnt  <= err_nxt;
      end
   end

`ifdef BIST_FAIL_CAPTURE_EN
   // Latch the first failing vector of a run; cleared when a new run starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_vld <= 1'b0;
         fail_a   <= '0;
         fail_b   <= '0;
         fail_cin <= 1'b0;
         fail_idx <= '0;
      end else if (start_run) begin
         fail_vld <= 1'b0;
         fail_a   <= '0;
         fail_b   <= '0;
         fail_cin <= 1'b0;
         fail_idx <= '0;
      end else if ((state == S_CHECK) && mismatch && !fail_vld) begin
         fail_vld <= 1'b1;
         fail_a   <= op_a;
         fail_b   <= op_b;
         fail_cin <= op_cin;
         fail_idx <= vec_cnt;
      end
   end
`endif

endmodule
